// File: rtl/pulpino_gpio_pkg.sv
// Shared definitions for the PULPino GPIO byte-channel master.
// Bit positions on the core GPIO ports and the transfer FSM states.
package pulpino_gpio_pkg;

  localparam int DATA_LSB = 0;
  localparam int DATA_MSB = 7;
  localparam int RD_TURN  = 8;
  localparam int RD_REQ   = 9;
  localparam int WR_TURN  = 10;
  localparam int WR_START = 11;
  localparam int RD_DONE  = 9;
  localparam int WR_DONE  = 11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_TURN,
    S_RD_WAIT,
    S_RD_CAP,
    S_RD_DONE,
    S_WR_START,
    S_WR_TURN,
    S_WR_WAIT,
    S_WR_DONE
  } xfer_state_e;

endpackage

// File: rtl/gpio_xfer_master_bit_sync.sv
// Multi-stage flop chain bringing core GPIO outputs into our clock.
// Width and depth are parameters; reset clears every stage.
module bit_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] chain_q [STAGES];

  // shift the sample one stage deeper each cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/gpio_xfer_master.sv
// Host-side word transfer sequencer over the core GPIO toggle handshake.
// One command becomes NBYTES byte handshakes, LSB first, each timeout-guarded.
module gpio_xfer_master
  import pulpino_gpio_pkg::*;
#(
  parameter int NBYTES      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] p_gpio_in,
  input  logic [31:0] p_gpio_out
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [1:0] CNT_LAST = 2'(NBYTES - 1);

  xfer_state_e state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rbuf_q, rbuf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    wbyte_q, wbyte_d;
  logic rd_turn_q, rd_turn_d;
  logic rd_req_q, rd_req_d;
  logic wr_turn_q, wr_turn_d;
  logic wr_start_q, wr_start_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_err_q, rsp_err_d;
  logic rd_ack_q, wr_ack_q;

  logic [31:0] sync;
  logic rd_edge, wr_edge, tmo_exp;
  logic unused_hi;

  bit_sync #(
    .WIDTH  (32),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (p_gpio_out),
    .q_o (sync)
  );

  assign unused_hi = ^sync[31:12];
  assign rd_edge = sync[RD_TURN] ^ rd_ack_q;
  assign wr_edge = sync[WR_TURN] ^ wr_ack_q;
  assign tmo_exp = (tmo_q == TMO_LAST);

  // next state, handshake outputs and timeout bookkeeping
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = '0;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    rdata_d     = rdata_q;
    wbyte_d     = wbyte_q;
    rd_turn_d   = rd_turn_q;
    rd_req_d    = rd_req_q;
    wr_turn_d   = wr_turn_q;
    wr_start_d  = wr_start_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          wdata_d = cmd_wdata;
          cnt_d   = '0;
          rbuf_d  = '0;
          state_d = cmd_write ? S_WR_START : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        rd_req_d = 1'b1;
        state_d  = S_RD_TURN;
      end
      S_RD_TURN: begin
        rd_turn_d = ~rd_turn_q;
        state_d   = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (rd_edge) begin
          state_d = S_RD_CAP;
        end else if (tmo_exp) begin
          rd_req_d    = 1'b0;
          wr_start_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rdata_d     = rbuf_q;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RD_CAP: begin
        rbuf_d[{cnt_q, 3'b000} +: 8] = sync[DATA_MSB:DATA_LSB];
        if (cnt_q == CNT_LAST) begin
          state_d = S_RD_DONE;
        end else begin
          cnt_d   = cnt_q + 2'd1;
          state_d = S_RD_TURN;
        end
      end
      S_RD_DONE: begin
        if (sync[RD_DONE]) begin
          rd_req_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rdata_d     = rbuf_q;
          state_d     = S_IDLE;
        end else if (tmo_exp) begin
          rd_req_d    = 1'b0;
          wr_start_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rdata_d     = rbuf_q;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WR_START: begin
        wr_start_d = 1'b1;
        wbyte_d    = wdata_q[7:0];
        state_d    = S_WR_TURN;
      end
      S_WR_TURN: begin
        wr_turn_d = ~wr_turn_q;
        state_d   = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (wr_edge) begin
          wr_start_d = 1'b0;
          if (cnt_q == CNT_LAST) begin
            state_d = S_WR_DONE;
          end else begin
            cnt_d   = cnt_q + 2'd1;
            wbyte_d = wdata_q[15:8];
            wdata_d = {8'h00, wdata_q[31:8]};
            state_d = S_WR_TURN;
          end
        end else if (tmo_exp) begin
          rd_req_d    = 1'b0;
          wr_start_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WR_DONE: begin
        if (sync[WR_DONE]) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          state_d     = S_IDLE;
        end else if (tmo_exp) begin
          rd_req_d    = 1'b0;
          wr_start_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state, datapath and ack history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      rdata_q     <= '0;
      wbyte_q     <= '0;
      rd_turn_q   <= 1'b0;
      rd_req_q    <= 1'b0;
      wr_turn_q   <= 1'b0;
      wr_start_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_ack_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      rdata_q     <= rdata_d;
      wbyte_q     <= wbyte_d;
      rd_turn_q   <= rd_turn_d;
      rd_req_q    <= rd_req_d;
      wr_turn_q   <= wr_turn_d;
      wr_start_q  <= wr_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_ack_q    <= sync[RD_TURN];
      wr_ack_q    <= sync[WR_TURN];
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rdata_q;
  assign p_gpio_in = {20'h0, wr_start_q, wr_turn_q,
                      rd_req_q, rd_turn_q, wbyte_q};

endmodule

// File: tb/tb_gpio_xfer_master.sv
// Bench for gpio_xfer_master with a behavioural core-side GPIO model.
// Responses are checked against a queue of expectations.
module tb_gpio_xfer_master;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [31:0] p_gpio_in;
  logic [31:0] p_gpio_out;

  always #5 clk = ~clk;

  gpio_xfer_master #(
    .NBYTES      (4),
    .SYNC_STAGES (2),
    .TIMEOUT     (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .p_gpio_in  (p_gpio_in),
    .p_gpio_out (p_gpio_out)
  );

  // core model controls (driven by the stimulus block only)
  logic        model_ack = 1'b1;
  int          model_delay = 2;
  logic [31:0] model_word = '0;
  logic        model_echo = 1'b0;

  // core model state (written by the model only)
  logic [11:0] mout;
  logic        seen_rt, seen_wt, seen_req, seen_start;
  logic        rd_pend, wr_pend;
  int          rd_dly, wr_dly;
  logic [2:0]  rd_idx, wr_idx;
  logic [7:0]  rx_byte [4];
  int          wr_total, unstable;
  logic [7:0]  prev_data;
  logic [31:0] rd_src;

  assign p_gpio_out = {20'h0, mout};
  assign rd_src = model_echo ?
    {rx_byte[3], rx_byte[2], rx_byte[1], rx_byte[0]} : model_word;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mout <= '0;
      seen_rt <= 1'b0; seen_wt <= 1'b0;
      seen_req <= 1'b0; seen_start <= 1'b0;
      rd_pend <= 1'b0; wr_pend <= 1'b0;
      rd_dly <= 0; wr_dly <= 0;
      rd_idx <= '0; wr_idx <= '0;
      for (int i = 0; i < 4; i++) rx_byte[i] <= '0;
      wr_total <= 0; unstable <= 0;
      prev_data <= '0;
    end else begin
      prev_data  <= p_gpio_in[7:0];
      seen_req   <= p_gpio_in[9];
      seen_start <= p_gpio_in[11];
      if (seen_req && !p_gpio_in[9]) begin
        mout[9] <= 1'b0;
        rd_idx  <= '0;
        rd_pend <= 1'b0;
      end else if (p_gpio_in[8] != seen_rt) begin
        seen_rt <= p_gpio_in[8];
        rd_pend <= 1'b1;
        rd_dly  <= 0;
      end else if (rd_pend && model_ack) begin
        if (rd_dly == model_delay) begin
          mout[7:0] <= rd_src[{rd_idx[1:0], 3'b000} +: 8];
          mout[8]   <= ~mout[8];
          rd_pend   <= 1'b0;
          rd_idx    <= rd_idx + 3'd1;
          if (rd_idx == 3'd3) mout[9] <= 1'b1;
        end else begin
          rd_dly <= rd_dly + 1;
        end
      end
      if (!seen_start && p_gpio_in[11]) begin
        mout[11] <= 1'b0;
        wr_idx   <= '0;
      end else if (p_gpio_in[10] != seen_wt) begin
        seen_wt <= p_gpio_in[10];
        if (p_gpio_in[7:0] != prev_data) unstable <= unstable + 1;
        rx_byte[wr_idx[1:0]] <= p_gpio_in[7:0];
        wr_idx   <= wr_idx + 3'd1;
        wr_total <= wr_total + 1;
        wr_pend  <= 1'b1;
        wr_dly   <= 0;
      end else if (wr_pend && model_ack) begin
        if (wr_dly == model_delay) begin
          mout[10] <= ~mout[10];
          wr_pend  <= 1'b0;
          if (wr_idx == 3'd4) mout[11] <= 1'b1;
        end else begin
          wr_dly <= wr_dly + 1;
        end
      end
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        chk_rd;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, want);
    end
  endtask

  // issue one command; return turn-toggle-to-response latency and toggles
  task automatic run_cmd(input logic wr, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_rd,
                         input logic chk_rd, input bit hold,
                         output int lat, output int toggles);
    exp_t e;
    bit   got;
    int   t_turn;
    logic last_rt;
    exp_q.push_back('{e_err, e_rd, chk_rd});
    cmd_write = wr;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    got = 0; lat = -1; toggles = 0; t_turn = -1;
    last_rt = p_gpio_in[8];
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      if (p_gpio_in[8] != last_rt) begin
        toggles++;
        last_rt = p_gpio_in[8];
        if (t_turn < 0) t_turn = i;
      end
      if (rsp_valid) begin
        got = 1;
        cmd_valid = 1'b0;
        e = exp_q.pop_front();
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
        if (e.chk_rd) chk("rsp_rdata", rsp_rdata, e.rdata);
        lat = i - t_turn;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      cmd_valid = 1'b0;
      void'(exp_q.pop_front());
      checks++;
      failures++;
      $error("FAIL rsp_wait observed=none expected=rsp_valid");
    end
  endtask

  int lat, tog, base;
  bit reached;

  initial begin
    model_word = 32'h1337_4242;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio_in", p_gpio_in, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    @(posedge clk); #1;

    // plain read
    run_cmd(1'b0, 32'h0, 1'b0, 32'h1337_4242, 1'b1, 0, lat, tog);
    chk("rd_toggles", tog, 4);
    chk("rd_req_low", {31'h0, p_gpio_in[9]}, 32'h0);
    chk("rd_busy", {31'h0, busy}, 32'h0);

    // plain write
    base = wr_total;
    run_cmd(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 0, lat, tog);
    chk("wr_bytes",
        {rx_byte[3], rx_byte[2], rx_byte[1], rx_byte[0]}, 32'hDEAD_BEEF);
    chk("wr_count", wr_total - base, 4);
    chk("wr_stable", unstable, 0);

    // core never acks
    model_ack = 1'b0;
    run_cmd(1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 0, lat, tog);
    chk("tmo_latency", lat, TMO);
    chk("tmo_req_low", {31'h0, p_gpio_in[9]}, 32'h0);
    chk("tmo_turn", {31'h0, p_gpio_in[8]}, 32'h1);
    @(posedge clk); #1;
    chk("tmo_ready", {31'h0, cmd_ready}, 32'h1);
    model_ack = 1'b1;

    // back-to-back write then echo read, cmd_valid held during write
    base = wr_total;
    run_cmd(1'b1, 32'hA5A5_0F0F, 1'b0, 32'h0, 1'b0, 1, lat, tog);
    chk("b2b_wr_count", wr_total - base, 4);
    model_echo = 1'b1;
    run_cmd(1'b0, 32'h0, 1'b0, 32'hA5A5_0F0F, 1'b1, 0, lat, tog);
    model_echo = 1'b0;
    chk("b2b_wr_count_after", wr_total - base, 4);

    // ack lands on the last timeout count: ack wins
    model_delay = 11;
    run_cmd(1'b0, 32'h0, 1'b0, 32'h1337_4242, 1'b1, 0, lat, tog);
    // one cycle later: timeout wins, nothing captured
    model_delay = 12;
    run_cmd(1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 0, lat, tog);
    model_delay = 2;

    // reset during the third byte of a write
    base = wr_total;
    cmd_write = 1'b1;
    cmd_wdata = 32'h1122_3344;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      if (wr_total - base == 2) reached = 1;
      else begin @(posedge clk); #1; end
    end
    chk("mid_reached", {31'h0, reached}, 32'h1);
    chk("mid_busy_pre", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_gpio_in", p_gpio_in, 32'h0);
    chk("mid_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_ready", {31'h0, cmd_ready}, 32'h1);
    @(posedge clk); #1;
    run_cmd(1'b0, 32'h0, 1'b0, 32'h1337_4242, 1'b1, 0, lat, tog);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_xfer_master.md
# gpio_xfer_master

Host-side controller that sequences 32-bit word transfers to and from the PULPino core over its GPIO toggle-handshake byte channel. Sits in the CW305 top level between the host register block (command/response interface) and the core's 32-bit GPIO ports. It converts one command into four byte handshakes, LSB first, and guards every handshake with a timeout.

## Interface
Parameters:
- NBYTES, 4, bytes per transfer; the shift logic supports 1..4.
- SYNC_STAGES, 2, flop stages on `p_gpio_out` before use; valid range 2..3.
- TIMEOUT, 1024, cycles allowed per handshake wait before abort; must be ≥ 4.

Ports (clock and reset first):
- `clk` in 1: single clock. One clock; reset is asynchronous and active-high.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_write` in 1: 1 = write word to core, 0 = read word from core.
- `cmd_wdata` in 32: write word; byte 0 (bits 7:0) is sent first.
- `rsp_valid` out 1: one-cycle pulse when a command completes or aborts.
- `rsp_rdata` out 32: read word, held until the next response.
- `rsp_err` out 1: qualified by `rsp_valid`; 1 = timeout abort.
- `busy` out 1: high whenever the state is not IDLE.
- `p_gpio_in` out 32: drives the core GPIO inputs. [7:0] wdata, [8] read turn, [9] read request, [10] write turn, [11] write start, [31:12] held 0.
- `p_gpio_out` in 32: core GPIO outputs. [7:0] rdata, [8] read ack toggle, [9] read done, [10] write ack toggle, [11] write done.

## Operation
- Reset: every output bit is 0. This includes `p_gpio_in`, both turn bits, `rsp_*`, `busy` and the counters. `cmd_ready` is 1 once reset is released.
- A command is accepted on `cmd_valid && cmd_ready`. The controller registers `cmd_wdata`/`cmd_write` and loads byte counter = 0.
- Ack edge: the synced ack bit differs from its value one cycle earlier.
- States and transitions:
  - IDLE: on accept, go to RD_REQ if read, WR_START if write.
  - RD_REQ: drive [9]=1 for one cycle → RD_TURN.
  - RD_TURN: invert [8]; clear the timeout counter → RD_WAIT.
  - RD_WAIT: on a read ack edge → RD_CAP.
  - RD_CAP: one cycle later, capture synced [7:0] into byte slot `cnt`. If `cnt` = NBYTES-1, go to RD_DONE; otherwise increment `cnt` and go to RD_TURN.
  - RD_DONE: wait for synced [9] = 1. Then drop [9], pulse `rsp_valid` → IDLE.
  - WR_START: drive [11]=1 and place byte 0 on [7:0] → WR_TURN.
  - WR_TURN: invert [10] → WR_WAIT. Data is therefore stable at least one cycle before the toggle.
  - WR_WAIT: on a write ack edge, drop [11]. If `cnt` = NBYTES-1, go to WR_DONE; otherwise increment `cnt`, load the next byte on [7:0] → WR_TURN.
  - WR_DONE: wait for synced [11] = 1, then pulse `rsp_valid`, `rsp_err`=0 → IDLE.
- Timeout:
  - The counter runs in every *_WAIT and *_DONE state.
  - On reaching TIMEOUT-1: drop [9] and [11], pulse `rsp_valid` with `rsp_err`=1, return to IDLE.
  - Turn bits keep their current value and are never re-zeroed except by reset, so the core stays turn-consistent.
  - `rsp_rdata` after a read abort holds the bytes captured so far. Uncaptured bytes are 0.
- `cmd_valid` is ignored while busy; no queueing.
- Simultaneous ack edge and timeout expiry in the same cycle: the ack wins.

## Timing
- `p_gpio_out` passes through a SYNC_STAGES flop chain, so ack detection lags the core by SYNC_STAGES+1 cycles.
- All `p_gpio_in` bits are registered outputs with no combinational path from `p_gpio_out`.
- Minimum read latency is 1 + NBYTES·(3 + SYNC_STAGES + core delay) + done wait.
- `rsp_valid` rises on the cycle after the final condition is met.
- Assertion of `rst` mid-transfer clears everything immediately, including the turn bits. Resetting the core at the same time is the integrator's duty.

## Structure
- Shared package `pulpino_gpio_pkg` holds:
  - GPIO bit-index constants: DATA_LSB=0, DATA_MSB=7, RD_TURN=8, RD_REQ=9, WR_TURN=10, WR_START=11, RD_DONE=9, WR_DONE=11.
  - The state enum.
- One sub-module: `bit_sync`, a parameterised-width SYNC_STAGES flop chain with asynchronous reset, instantiated 32 wide.

## Test plan
- Read against a core model holding 0x1337_4242 → `rsp_rdata`=0x1337_4242, `rsp_err`=0, read turn toggled 4 times, [9] low after completion.
- Write 0xDEAD_BEEF → model receives bytes EF, BE, AD, DE in order, each stable when its turn toggles. Then `rsp_valid` with `rsp_err`=0.
- Model never acks, TIMEOUT=16 → `rsp_valid`+`rsp_err`=1 exactly 16 cycles after RD_WAIT entry, [9]=0, read turn left at 1, `cmd_ready`=1 next cycle.
- Back-to-back: write 0xA5A5_0F0F, then a read from the model echoing the written word → read returns 0xA5A5_0F0F. `cmd_valid` held high during the write is not accepted twice.
- `rst` asserted during byte 2 of a write → same cycle `p_gpio_in`=0 and `busy`=0. After release, `cmd_ready`=1.
- Ack edge in the same cycle as the final timeout count → transfer continues, `rsp_err`=0.
